// File: rtl/iiitb_lifo_pkg.sv
// Shared types and constants for the LIFO arbiter and its round-robin picker.
package iiitb_lifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  localparam int LIFO_DW    = 4;
  localparam int LIFO_DEPTH = 8;

  // A push into a full LIFO or a pop from an empty one is rejected without access.
  function automatic logic op_illegal(input logic op, input logic full, input logic empty);
    return (op == OP_PUSH) ? full : empty;
  endfunction

endpackage

// File: rtl/iiitb_rr_arb2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to rr_i.
module iiitb_rr_arb2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic rr_i,
  output logic gnt_id_o,
  output logic gnt_any_o
);

  assign gnt_any_o = req0_i | req1_i;
  assign gnt_id_o  = (req0_i & req1_i) ? rr_i : req1_i;

endmodule

// File: rtl/iiitb_lifo_arbiter.sv
// Shares one LIFO between two clients: arbitrates, sequences EN/RW/dataIn,
// rejects push-when-full / pop-when-empty, returns pop data and tracks level.
module iiitb_lifo_arbiter
  import iiitb_lifo_pkg::*;
#(
  parameter  int DW    = LIFO_DW,
  parameter  int DEPTH = LIFO_DEPTH,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          req0,
  input  logic          rw0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic          err0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          rw1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic          err1,
  output logic [DW-1:0] rdata1,
  output logic          lifo_EN,
  output logic          lifo_RW,
  output logic [DW-1:0] lifo_dataIn,
  input  logic [DW-1:0] lifo_dataOut,
  input  logic          lifo_EMPTY,
  input  logic          lifo_FULL,
  output logic [LW-1:0] level,
  output logic          busy
);

  localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);

  state_e        state_q, state_d;
  logic          rr_q, rr_d;
  logic          win_q, win_d;
  logic          op_q, op_d;
  logic          rej_q, rej_d;
  logic          en_q, en_d;
  logic          rw_q, rw_d;
  logic [DW-1:0] din_q, din_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          err0_q, err0_d;
  logic          err1_q, err1_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic [LW-1:0] level_q, level_d;

  logic gnt_id;
  logic gnt_any;

  iiitb_rr_arb2 u_rr_arb2 (
    .req0_i   (req0),
    .req1_i   (req1),
    .rr_i     (rr_q),
    .gnt_id_o (gnt_id),
    .gnt_any_o(gnt_any)
  );

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    win_d    = win_q;
    op_d     = op_q;
    rej_d    = rej_q;
    en_d     = 1'b0;
    rw_d     = rw_q;
    din_d    = din_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    level_d  = level_q;

    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          win_d = gnt_id;
          op_d  = gnt_id ? rw1 : rw0;
          rej_d = op_illegal(op_d, lifo_FULL, lifo_EMPTY);
          if (rej_d) begin
            state_d = DONE;
          end else begin
            state_d = ISSUE;
            en_d    = 1'b1;
            rw_d    = op_d;
            din_d   = (op_d == OP_PUSH) ? (gnt_id ? wdata1 : wdata0) : '0;
          end
        end
      end

      ISSUE: begin
        state_d = DONE;
      end

      DONE: begin
        ack0_d = ~win_q;
        ack1_d = win_q;
        err0_d = ~win_q & rej_q;
        err1_d = win_q & rej_q;
        // Pop data became valid on dataOut after the ISSUE edge; take it now.
        if (!rej_q) begin
          if (op_q == OP_POP) begin
            if (win_q) rdata1_d = lifo_dataOut;
            else       rdata0_d = lifo_dataOut;
            if (level_q != '0) level_d = level_q - 1'b1;
          end else begin
            if (level_q != LVL_MAX) level_d = level_q + 1'b1;
          end
        end
        rr_d    = ~win_q;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      win_q    <= 1'b0;
      op_q     <= OP_PUSH;
      rej_q    <= 1'b0;
      en_q     <= 1'b0;
      rw_q     <= 1'b0;
      din_q    <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      win_q    <= win_d;
      op_q     <= op_d;
      rej_q    <= rej_d;
      en_q     <= en_d;
      rw_q     <= rw_d;
      din_q    <= din_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      level_q  <= level_d;
    end
  end

  assign lifo_EN     = en_q;
  assign lifo_RW     = rw_q;
  assign lifo_dataIn = din_q;
  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign err0        = err0_q;
  assign err1        = err1_q;
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;
  assign level       = level_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_iiitb_lifo_arbiter.sv
// Directed bench for iiitb_lifo_arbiter with a behavioural 8-deep LIFO attached.
module tb_iiitb_lifo_arbiter;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       req0, rw0, req1, rw1;
  logic [3:0] wdata0, wdata1;
  logic       ack0, err0, ack1, err1;
  logic [3:0] rdata0, rdata1;
  logic       lifo_EN, lifo_RW;
  logic [3:0] lifo_dataIn, lifo_dataOut;
  logic       lifo_EMPTY, lifo_FULL;
  logic [3:0] level;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int en_cnt   = 0;
  int ack0_cnt = 0;
  int ack1_cnt = 0;
  logic [3:0] exp_rd0 = 4'h0;
  logic [3:0] exp_rd1 = 4'h0;

  always #5 Clk = ~Clk;

  iiitb_lifo_arbiter dut (
    .Clk(Clk), .Rst(Rst),
    .req0(req0), .rw0(rw0), .wdata0(wdata0), .ack0(ack0), .err0(err0), .rdata0(rdata0),
    .req1(req1), .rw1(rw1), .wdata1(wdata1), .ack1(ack1), .err1(err1), .rdata1(rdata1),
    .lifo_EN(lifo_EN), .lifo_RW(lifo_RW), .lifo_dataIn(lifo_dataIn),
    .lifo_dataOut(lifo_dataOut), .lifo_EMPTY(lifo_EMPTY), .lifo_FULL(lifo_FULL),
    .level(level), .busy(busy)
  );

  // Behavioural LIFO: acts on the EN edge, flags and dataOut valid the cycle after.
  logic [3:0] mem [8];
  int         sp;
  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sp <= 0;
      lifo_dataOut <= 4'h0;
    end else if (lifo_EN) begin
      if (!lifo_RW && sp < 8) begin
        mem[sp] <= lifo_dataIn;
        sp <= sp + 1;
      end else if (lifo_RW && sp > 0) begin
        lifo_dataOut <= mem[sp-1];
        sp <= sp - 1;
      end
    end
  end
  assign lifo_EMPTY = (sp == 0);
  assign lifo_FULL  = (sp == 8);

  always @(negedge Clk) begin
    if (lifo_EN) en_cnt++;
    if (ack0) ack0_cnt++;
    if (ack1) ack1_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_any(output int k, output logic a0, output logic a1);
    k = 0; a0 = 1'b0; a1 = 1'b0;
    while (!(a0 | a1) && k < 12) begin
      @(posedge Clk); #1;
      k++;
      a0 = ack0;
      a1 = ack1;
    end
  endtask

  task automatic do_reset();
    #1 Rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
    exp_rd0 = 4'h0;
    exp_rd1 = 4'h0;
  endtask

  task automatic do_op(input logic cl, input logic rw, input logic [3:0] wd,
                       input logic exp_err, input logic [3:0] exp_rd,
                       input logic [3:0] exp_lvl, input string tag);
    int   k;
    int   en0;
    logic got;
    @(posedge Clk); #1;
    if (cl) begin req1 = 1'b1; rw1 = rw; wdata1 = wd; end
    else    begin req0 = 1'b1; rw0 = rw; wdata0 = wd; end
    en0 = en_cnt; got = 1'b0; k = 0;
    while (!got && k < 10) begin
      @(posedge Clk); #1;
      k++;
      if (k == 1 && !exp_err) begin
        chk({tag, " issue_en"}, lifo_EN, 1'b1);
        chk({tag, " issue_rw"}, lifo_RW, rw);
        chk({tag, " issue_din"}, lifo_dataIn, rw ? 4'h0 : wd);
      end
      got = cl ? ack1 : ack0;
    end
    req0 = 1'b0; req1 = 1'b0;
    chk({tag, " ack_seen"}, got, 1'b1);
    if (got) begin
      chk({tag, " latency"}, k, exp_err ? 2 : 3);
      chk({tag, " err"}, cl ? err1 : err0, exp_err);
      chk({tag, " other_ack"}, cl ? ack0 : ack1, 1'b0);
      chk({tag, " other_err"}, cl ? err0 : err1, 1'b0);
      chk({tag, " level"}, level, exp_lvl);
      if (!exp_err && rw) begin
        if (cl) exp_rd1 = exp_rd; else exp_rd0 = exp_rd;
      end
      chk({tag, " rdata0"}, rdata0, exp_rd0);
      chk({tag, " rdata1"}, rdata1, exp_rd1);
      chk({tag, " en_pulses"}, en_cnt - en0, exp_err ? 0 : 1);
      @(posedge Clk); #1;
      chk({tag, " ack_one_cycle"}, {ack0, ack1, err0, err1}, 4'h0);
    end
  endtask

  typedef struct {
    logic       cl;
    logic       rw;
    logic [3:0] wd;
    logic       exp_err;
    logic [3:0] exp_rd;
    logic [3:0] exp_lvl;
  } vec_t;

  vec_t tbl [21];

  initial begin
    int   k;
    int   cnt0;
    logic a0, a1;
    logic [3:0] wd;

    tbl[0]  = '{1'b1, 1'b1, 4'h0, 1'b1, 4'h0, 4'd0};
    tbl[1]  = '{1'b0, 1'b0, 4'h6, 1'b0, 4'h0, 4'd1};
    tbl[2]  = '{1'b0, 1'b1, 4'h0, 1'b0, 4'h6, 4'd0};
    for (int i = 0; i < 8; i++) tbl[3+i] = '{1'b0, 1'b0, 4'(i), 1'b0, 4'h0, 4'(i+1)};
    tbl[11] = '{1'b0, 1'b0, 4'hF, 1'b1, 4'h0, 4'd8};
    tbl[12] = '{1'b1, 1'b1, 4'h0, 1'b0, 4'h7, 4'd7};
    for (int i = 13; i < 20; i++) tbl[i] = '{1'b0, 1'b1, 4'h0, 1'b0, 4'(19-i), 4'(19-i)};
    tbl[20] = '{1'b0, 1'b1, 4'h0, 1'b1, 4'h0, 4'd0};

    Rst = 1'b1;
    req0 = 1'b0; rw0 = 1'b0; wdata0 = 4'h0;
    req1 = 1'b0; rw1 = 1'b0; wdata1 = 4'h0;
    #2;
    chk("rst outputs", {ack0, ack1, err0, err1, lifo_EN, lifo_RW, busy}, 7'h0);
    chk("rst rdata", {rdata0, rdata1}, 8'h00);
    chk("rst level", level, 4'd0);
    chk("rst dataIn", lifo_dataIn, 4'h0);
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;

    for (int i = 0; i < 21; i++)
      do_op(tbl[i].cl, tbl[i].rw, tbl[i].wd, tbl[i].exp_err, tbl[i].exp_rd,
            tbl[i].exp_lvl, $sformatf("vec%0d", i));

    // Tie after reset: client 0 first, then the waiting client 1.
    do_reset();
    @(posedge Clk); #1;
    req0 = 1'b1; rw0 = 1'b0; wdata0 = 4'h2;
    req1 = 1'b1; rw1 = 1'b0; wdata1 = 4'h4;
    wait_any(k, a0, a1);
    chk("tie first_is_c0", {a0, a1}, 2'b10);
    chk("tie first_latency", k, 3);
    req0 = 1'b0;
    wait_any(k, a0, a1);
    chk("tie second_is_c1", {a0, a1}, 2'b01);
    chk("tie second_latency", k, 3);
    req1 = 1'b0;
    chk("tie level", level, 4'd2);
    do_op(1'b1, 1'b1, 4'h0, 1'b0, 4'h4, 4'd1, "tie pop_a");
    do_op(1'b1, 1'b1, 4'h0, 1'b0, 4'h2, 4'd0, "tie pop_b");

    // Continuous dual requests alternate grants.
    @(posedge Clk); #1;
    req0 = 1'b1; rw0 = 1'b0; wdata0 = 4'h1;
    req1 = 1'b1; rw1 = 1'b0; wdata1 = 4'h3;
    for (int g = 0; g < 4; g++) begin
      wait_any(k, a0, a1);
      chk($sformatf("alt grant%0d", g), {a0, a1}, (g % 2 == 0) ? 2'b10 : 2'b01);
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("alt level", level, 4'd4);

    // Stale req held one cycle past ack is served as a second push.
    do_reset();
    cnt0 = ack0_cnt;
    @(posedge Clk); #1;
    req0 = 1'b1; rw0 = 1'b0; wdata0 = 4'h9;
    wait_any(k, a0, a1);
    chk("stale first_ack", {a0, a1}, 2'b10);
    @(posedge Clk); #1;
    req0 = 1'b0;
    wait_any(k, a0, a1);
    chk("stale second_ack", {a0, a1}, 2'b10);
    chk("stale second_latency", k, 2);
    repeat (4) @(posedge Clk);
    #1;
    chk("stale ack_count", ack0_cnt - cnt0, 2);
    chk("stale level", level, 4'd2);

    // Reset while EN is high drops the transaction.
    @(posedge Clk); #1;
    req0 = 1'b1; rw0 = 1'b0; wdata0 = 4'h5;
    @(posedge Clk); #1;
    chk("midrst en_before", {lifo_EN, busy}, 2'b11);
    #1 Rst = 1'b1;
    #1;
    chk("midrst en_after", lifo_EN, 1'b0);
    chk("midrst busy", busy, 1'b0);
    chk("midrst level", level, 4'd0);
    chk("midrst acks", {ack0, ack1}, 2'b00);
    req0 = 1'b0;
    cnt0 = ack0_cnt;
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
    exp_rd0 = 4'h0; exp_rd1 = 4'h0;
    repeat (5) @(posedge Clk);
    #1;
    chk("midrst no_ack", ack0_cnt - cnt0, 0);
    chk("midrst lifo_empty", lifo_EMPTY, 1'b1);
    do_op(1'b1, 1'b1, 4'h0, 1'b1, 4'h0, 4'd0, "midrst pop_reject");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
